// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the wall-clock slice: the button conditioner state
// encoding, default timing constants at 100 MHz, and a counter-width helper.
// Also imported by the wall clock and the display driver.
// -----------------------------------------------------------------------------
package clock_pkg;

   // Button conditioner FSM states
   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_HELD_DELAY  = 2'd1,
      ST_HELD_REPEAT = 2'd2
   } btn_state_e;

   // Default timing constants, in 100 MHz clock cycles
   localparam int DEF_DEBOUNCE_CYCLES     = 1000000;   // 10 ms
   localparam int DEF_REPEAT_DELAY_CYCLES = 50000000;  // 0.5 s
   localparam int DEF_REPEAT_RATE_CYCLES  = 20000000;  // 0.2 s

   // Counter width for a count limit: one spare bit so the counter can
   // never wrap while it is compared against its limit.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

   // Larger of two widths, used when one counter serves two limits
   function automatic int max_width(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Groups the button conditioner's functional signals.
//   btn_in        raw push-button level (1 = pressed), asynchronous
//   repeat_en     auto-repeat enable, sampled every cycle
//   pressed       debounced button level
//   press_pulse   one-cycle strobe on press and on each auto-repeat
//   release_pulse one-cycle strobe on release
//   long_hold     high from the first auto-repeat point until release
// master: the side that owns the button (drives btn_in / repeat_en)
// slave : the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if;

   logic btn_in;
   logic repeat_en;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic long_hold;

   modport master (
      output btn_in,
      output repeat_en,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_hold
   );

   modport slave (
      input  btn_in,
      input  repeat_en,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_hold
   );

endinterface

// File: rtl/button_conditioner_chk.sv
// -----------------------------------------------------------------------------
// button_conditioner_chk
// Simulation-only property checks on the conditioner outputs.
//   CLK100MHZ, reset                 clock and synchronous reset
//   pressed, press_pulse,
//   release_pulse, long_hold         observed conditioner outputs
// Contains no logic; synthesis ignores the assertions.
// -----------------------------------------------------------------------------
module button_conditioner_chk (
   input logic CLK100MHZ,
   input logic reset,
   input logic pressed,
   input logic press_pulse,
   input logic release_pulse,
   input logic long_hold
);

   // A press strobe and a release strobe never coincide
   a_pulse_exclusive : assert property (@(posedge CLK100MHZ) disable iff (reset)
      !(press_pulse && release_pulse));

   // Each strobe lasts exactly one cycle
   a_press_one_cycle : assert property (@(posedge CLK100MHZ) disable iff (reset)
      press_pulse |=> !press_pulse);

   a_release_one_cycle : assert property (@(posedge CLK100MHZ) disable iff (reset)
      release_pulse |=> !release_pulse);

   // A long hold only exists while the button is accepted as pressed
   a_long_hold_pressed : assert property (@(posedge CLK100MHZ) disable iff (reset)
      long_hold |-> pressed);

   // A press strobe always accompanies a pressed level
   a_press_pressed : assert property (@(posedge CLK100MHZ) disable iff (reset)
      press_pulse |-> pressed);

endmodule

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Two-flop synchronizer followed by a stable-sample debounce counter.
//   CLK100MHZ  in   system clock
//   reset      in   synchronous active-high reset
//   btn_in     in   raw asynchronous button level
//   pressed    out  debounced level (registered)
//   rise_evt   out  pressed will go 0->1 on the next edge
//   fall_evt   out  pressed will go 1->0 on the next edge
// The event outputs are look-ahead strobes so the parent can register its
// press/release pulses on the same edge that pressed changes.
// -----------------------------------------------------------------------------
module debounce_filter
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic btn_in,
   output logic pressed,
   output logic rise_evt,
   output logic fall_evt
);

   localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DB_ONE  = CW'(1);

   logic          sync1_r;
   logic          sync2_r;
   logic          pressed_r;
   logic [CW-1:0] db_cnt_r;
   logic          differ_s;
   logic          toggle_s;

   // Change detect and acceptance: the level flips once the counter has seen
   // DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      differ_s = sync2_r ^ pressed_r;
      toggle_s = differ_s && (db_cnt_r == DB_LAST);
   end

   // Synchronizer, debounce counter and accepted level
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         pressed_r <= 1'b0;
         db_cnt_r  <= '0;
      end else begin
         sync1_r <= btn_in;
         sync2_r <= sync1_r;
         if (toggle_s) begin
            pressed_r <= ~pressed_r;
            db_cnt_r  <= '0;
         end else if (differ_s) begin
            // Cannot wrap: acceptance at DB_LAST clears it first
            db_cnt_r <= db_cnt_r + DB_ONE;
         end else begin
            db_cnt_r <= '0;
         end
      end
   end

   assign pressed  = pressed_r;
   assign rise_evt = toggle_s & ~pressed_r;
   assign fall_evt = toggle_s &  pressed_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Debounces a push button and generates press / auto-repeat / release strobes
// for the wall-clock set buttons.
//   CLK100MHZ  in   system clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   bus        slave modport of button_conditioner_if:
//                btn_in, repeat_en in; pressed, press_pulse, release_pulse,
//                long_hold out (all outputs registered)
// Parameters (in clock cycles): DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
// REPEAT_RATE_CYCLES.
// -----------------------------------------------------------------------------
module button_conditioner
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic                  CLK100MHZ,
   input  logic                  reset,
   button_conditioner_if.slave   bus
);

   // One hold counter serves both the initial delay and the repeat spacing
   localparam int            HW         = max_width(cnt_width(REPEAT_DELAY_CYCLES),
                                                    cnt_width(REPEAT_RATE_CYCLES));
   localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

   logic          pressed_s;
   logic          rise_evt_s;
   logic          fall_evt_s;

   btn_state_e    state_r;
   btn_state_e    state_s;
   logic [HW-1:0] hold_cnt_r;
   logic [HW-1:0] hold_cnt_s;
   logic          press_pulse_r;
   logic          press_pulse_s;
   logic          release_pulse_r;
   logic          release_pulse_s;
   logic          long_hold_r;
   logic          long_hold_s;

   debounce_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .btn_in    (bus.btn_in),
      .pressed   (pressed_s),
      .rise_evt  (rise_evt_s),
      .fall_evt  (fall_evt_s)
   );

   // Next-state and next-output logic. The hold counter value in a cycle is
   // the number of cycles since the last strobe, so a limit of N fires the
   // next strobe N cycles after the previous one. A release always wins over
   // a coinciding repeat point.
   always_comb begin
      state_s         = state_r;
      hold_cnt_s      = hold_cnt_r;
      press_pulse_s   = 1'b0;
      release_pulse_s = 1'b0;
      long_hold_s     = long_hold_r;

      if (fall_evt_s) begin
         state_s         = ST_IDLE;
         hold_cnt_s      = '0;
         release_pulse_s = 1'b1;
         long_hold_s     = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               hold_cnt_s  = '0;
               long_hold_s = 1'b0;
               if (rise_evt_s) begin
                  state_s       = ST_HELD_DELAY;
                  press_pulse_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end

            ST_HELD_DELAY: begin
               if (hold_cnt_r >= DELAY_LAST) begin
                  long_hold_s = 1'b1;
                  if (bus.repeat_en) begin
                     state_s       = ST_HELD_REPEAT;
                     press_pulse_s = 1'b1;
                     hold_cnt_s    = '0;
                  end else begin
                     // Saturate at the delay point; the first repeat fires
                     // as soon as repeat_en is raised.
                     hold_cnt_s = DELAY_LAST;
                  end
               end else begin
                  hold_cnt_s = hold_cnt_r + HOLD_ONE;
               end
            end

            ST_HELD_REPEAT: begin
               if (bus.repeat_en) begin
                  if (hold_cnt_r >= RATE_LAST) begin
                     press_pulse_s = 1'b1;
                     hold_cnt_s    = '0;
                  end else begin
                     hold_cnt_s = hold_cnt_r + HOLD_ONE;
                  end
               end else begin
                  // Paused: counter frozen, repeat resumes where it left off
                  hold_cnt_s = hold_cnt_r;
               end
            end

            default: begin
               state_s     = ST_IDLE;
               hold_cnt_s  = '0;
               long_hold_s = 1'b0;
            end
         endcase
      end
   end

   // State, hold counter and registered strobes
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         hold_cnt_r      <= '0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         long_hold_r     <= 1'b0;
      end else begin
         state_r         <= state_s;
         hold_cnt_r      <= hold_cnt_s;
         press_pulse_r   <= press_pulse_s;
         release_pulse_r <= release_pulse_s;
         long_hold_r     <= long_hold_s;
      end
   end

   assign bus.pressed       = pressed_s;
   assign bus.press_pulse   = press_pulse_r;
   assign bus.release_pulse = release_pulse_r;
   assign bus.long_hold     = long_hold_r;

   button_conditioner_chk u_chk (
      .CLK100MHZ     (CLK100MHZ),
      .reset         (reset),
      .pressed       (pressed_s),
      .press_pulse   (press_pulse_r),
      .release_pulse (release_pulse_r),
      .long_hold     (long_hold_r)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench with DEBOUNCE=4, DELAY=10, RATE=3. Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the next rising edge. Tick k of
// each scenario is the k-th rising edge after the scenario's first input
// change, so pressed rises on tick 6 (two synchronizer edges plus four
// debounce edges).
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   logic CLK100MHZ = 1'b0;
   logic reset;
   int   tests_run    = 0;
   int   tests_failed = 0;

   button_conditioner_if bus ();

   button_conditioner #(
      .DEBOUNCE_CYCLES     (4),
      .REPEAT_DELAY_CYCLES (10),
      .REPEAT_RATE_CYCLES  (3)
   ) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .bus       (bus)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.btn_in    = 1'b0;
      bus.repeat_en = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tests_run++;
      if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_outputs got %b%b%b%b expected 0000",
                  bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tests_run++;
      if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL post_reset_idle got %b%b%b%b expected 0000",
                  bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold);
      end
   endtask

   // Press, hold one tick past acceptance, then release: both latencies 6
   task automatic test_press_latency();
      logic ep, epp, erp;
      bus.repeat_en = 1'b0;
      bus.btn_in    = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         if (k == 8) bus.btn_in = 1'b0;
         tick();
         ep  = (k >= 6 && k < 13);
         epp = (k == 6);
         erp = (k == 13);
         tests_run++;
         if (bus.pressed !== ep) begin
            tests_failed++;
            $display("FAIL latency_pressed k=%0d got %b expected %b", k, bus.pressed, ep);
         end
         tests_run++;
         if (bus.press_pulse !== epp) begin
            tests_failed++;
            $display("FAIL latency_press_pulse k=%0d got %b expected %b", k, bus.press_pulse, epp);
         end
         tests_run++;
         if (bus.release_pulse !== erp) begin
            tests_failed++;
            $display("FAIL latency_release_pulse k=%0d got %b expected %b", k, bus.release_pulse, erp);
         end
      end
      tick();
      tests_run++;
      if (bus.release_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL release_width got %b expected 0", bus.release_pulse);
      end
   endtask

   // Three-cycle glitch: nothing moves
   task automatic test_glitch();
      bus.btn_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) bus.btn_in = 1'b0;
         tick();
         tests_run++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL glitch k=%0d got %b%b%b%b expected 0000", k,
                     bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold);
         end
      end
   endtask

   // Four-cycle pulse: exactly long enough, pressed for ticks 6..9
   task automatic test_glitch_boundary();
      logic ep, epp, erp;
      bus.btn_in = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k == 5) bus.btn_in = 1'b0;
         tick();
         ep  = (k >= 6 && k < 10);
         epp = (k == 6);
         erp = (k == 10);
         tests_run++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse} !== {ep, epp, erp}) begin
            tests_failed++;
            $display("FAIL boundary_pulse k=%0d got %b%b%b expected %b%b%b", k,
                     bus.pressed, bus.press_pulse, bus.release_pulse, ep, epp, erp);
         end
      end
   endtask

   // Auto-repeat: press at 6, repeats at 16,19,...,40; release accepted at 42
   task automatic test_repeat();
      logic ep, epp, erp, elh;
      bus.repeat_en = 1'b1;
      bus.btn_in    = 1'b1;
      for (int k = 1; k <= 46; k++) begin
         if (k == 37) bus.btn_in = 1'b0;
         tick();
         ep  = (k >= 6 && k < 42);
         epp = (k == 6) || (k >= 16 && k < 42 && ((k - 16) % 3) == 0);
         erp = (k == 42);
         elh = (k >= 16 && k < 42);
         tests_run++;
         if (bus.press_pulse !== epp) begin
            tests_failed++;
            $display("FAIL repeat_press_pulse k=%0d got %b expected %b", k, bus.press_pulse, epp);
         end
         tests_run++;
         if (bus.long_hold !== elh) begin
            tests_failed++;
            $display("FAIL repeat_long_hold k=%0d got %b expected %b", k, bus.long_hold, elh);
         end
         tests_run++;
         if ({bus.pressed, bus.release_pulse} !== {ep, erp}) begin
            tests_failed++;
            $display("FAIL repeat_level k=%0d got %b%b expected %b%b", k,
                     bus.pressed, bus.release_pulse, ep, erp);
         end
      end
   endtask

   // Release accepted on tick 22, which is also a repeat point
   task automatic test_release_on_repeat();
      logic epp, erp, elh;
      bus.repeat_en = 1'b1;
      bus.btn_in    = 1'b1;
      for (int k = 1; k <= 26; k++) begin
         if (k == 17) bus.btn_in = 1'b0;
         tick();
         epp = (k == 6) || (k == 16) || (k == 19);
         erp = (k == 22);
         elh = (k >= 16 && k < 22);
         tests_run++;
         if ({bus.press_pulse, bus.release_pulse, bus.long_hold} !== {epp, erp, elh}) begin
            tests_failed++;
            $display("FAIL release_on_repeat k=%0d got %b%b%b expected %b%b%b", k,
                     bus.press_pulse, bus.release_pulse, bus.long_hold, epp, erp, elh);
         end
      end
   endtask

   // Repeat disabled: long_hold at 16, no pulses; enable after tick 25 ->
   // pulses at 26,29,32,35,38; release accepted at 39
   task automatic test_repeat_disabled();
      logic epp, erp, elh;
      bus.repeat_en = 1'b0;
      bus.btn_in    = 1'b1;
      for (int k = 1; k <= 42; k++) begin
         if (k == 26) bus.repeat_en = 1'b1;
         if (k == 34) bus.btn_in    = 1'b0;
         tick();
         epp = (k == 6) || (k >= 26 && k < 39 && ((k - 26) % 3) == 0);
         erp = (k == 39);
         elh = (k >= 16 && k < 39);
         tests_run++;
         if (bus.press_pulse !== epp) begin
            tests_failed++;
            $display("FAIL norepeat_press_pulse k=%0d got %b expected %b", k, bus.press_pulse, epp);
         end
         tests_run++;
         if ({bus.release_pulse, bus.long_hold} !== {erp, elh}) begin
            tests_failed++;
            $display("FAIL norepeat_release_hold k=%0d got %b%b expected %b%b", k,
                     bus.release_pulse, bus.long_hold, erp, elh);
         end
      end
   endtask

   // Reset while held: outputs clear, then a fresh 6-tick debounce
   task automatic test_reset_mid_hold();
      logic ep, epp;
      bus.repeat_en = 1'b1;
      bus.btn_in    = 1'b1;
      for (int k = 1; k <= 12; k++) tick();
      tests_run++;
      if (bus.pressed !== 1'b1) begin
         tests_failed++;
         $display("FAIL midhold_pressed_before_reset got %b expected 1", bus.pressed);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL midhold_reset got %b%b%b%b expected 0000",
                  bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold);
      end
      for (int k = 1; k <= 9; k++) begin
         tick();
         ep  = (k >= 6);
         epp = (k == 6);
         tests_run++;
         if ({bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold} !== {ep, epp, 2'b00}) begin
            tests_failed++;
            $display("FAIL midhold_recover k=%0d got %b%b%b%b expected %b%b00", k,
                     bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_hold, ep, epp);
         end
      end
      bus.btn_in = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      tests_run++;
      if (bus.pressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL midhold_final_release got %b expected 0", bus.pressed);
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_glitch_boundary();
      test_repeat();
      test_release_on_repeat();
      test_repeat_disabled();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
